// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer.
//   state_e    : sequencer FSM states (ST_IDLE = 0, ST_SCAN = 1)
//   cnt_width  : dwell counter width, max(1, $clog2(dwell))
package mux_scan_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  function automatic int cnt_width(input int dwell);
    return (dwell <= 2) ? 1 : $clog2(dwell);
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_dwell_timer.sv
// dwell_timer: counts cycles while enabled and flags the last cycle of
// each DWELL-cycle window.
//   clk  in  : clock, posedge
//   rst  in  : asynchronous active-high reset
//   en   in  : count enable; the count returns to 0 whenever en is low
//   tick out : high while enabled and cnt == DWELL-1
module dwell_timer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_width(DWELL);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && (cnt_q == CNT_LAST);

  // With DWELL=1 CNT_LAST is 0, so tick fires every enabled cycle and the
  // count never leaves 0.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks the select of a 2**SEL_W:1 mux through every
// channel, holding each for DWELL cycles, samples the mux output at the end
// of each dwell window and presents the assembled word with a 1-cycle valid.
//   clk   in  : clock, posedge
//   rst   in  : asynchronous active-high reset
//   start in  : begin a scan (level-sampled in IDLE only)
//   cont  in  : 1 = rescan back-to-back, 0 = one-shot
//   f     in  : mux output
//   s     out : mux select [SEL_W-1:0]
//   data  out : captured word [NCH-1:0], data[k] = f sampled while s == k
//   valid out : 1-cycle pulse when data updates
//   busy  out : high while a scan is in progress
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cont,
  input  logic                f,
  output logic [SEL_W-1:0]    s,
  output logic [2**SEL_W-1:0] data,
  output logic                valid,
  output logic                busy
);

  localparam int NCH = 2**SEL_W;
  localparam logic [SEL_W-1:0] S_LAST = SEL_W'(NCH - 1);

  state_e           state_q,  state_d;
  logic [SEL_W-1:0] s_q,      s_d;
  logic [NCH-1:0]   shadow_q, shadow_d;
  logic [NCH-1:0]   data_q,   data_d;
  logic             valid_q,  valid_d;
  logic             busy_q,   busy_d;
  logic             tick;

  dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == ST_SCAN),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          s_d     = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (tick) begin
          shadow_d[s_q] = f;
          s_d           = s_q + SEL_W'(1);  // wraps to 0 after the last channel
          if (s_q == S_LAST) begin
            // The last bit bypasses the shadow so data is complete on this edge.
            data_d  = {f, shadow_q[NCH-2:0]};
            valid_d = 1'b1;
            if (!cont) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign s     = s_q;
  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer. Two instances: defaults
// (SEL_W=2, DWELL=4) and DWELL=1. Each drives a behavioural 4:1 mux
// (f = a[s]) whose inputs a are set by the steps below.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cont;
  logic [3:0] a;
  logic       f;
  logic [1:0] s;
  logic [3:0] data;
  logic       valid, busy;

  logic       start1, cont1;
  logic [3:0] a1;
  logic       f1;
  logic [1:0] s1;
  logic [3:0] data1;
  logic       valid1, busy1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign f  = a[s];
  assign f1 = a1[s1];

  mux_scan_sequencer #(.SEL_W(2), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .f(f),
    .s(s), .data(data), .valid(valid), .busy(busy)
  );

  mux_scan_sequencer #(.SEL_W(2), .DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cont(cont1), .f(f1),
    .s(s1), .data(data1), .valid(valid1), .busy(busy1)
  );

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs of the default instance packed as {valid, busy, s, data}.
  function automatic logic [7:0] pk();
    return {valid, busy, s, data};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; a = 4'h0;
    start1 = 1'b0; cont1 = 1'b0; a1 = 4'h0;
    #2;
    check("reset_state", pk(), 8'h00);
    step(2);
    rst = 1'b0;
    step(1);

    // One-shot, a=1010. The edge after start=1 is T0.
    a = 4'b1010; start = 1'b1;
    step(1);                               // T0
    start = 1'b0;
    check("os_t0",   pk(), {1'b0, 1'b1, 2'd0, 4'h0});
    step(3);  check("os_t3_s", {6'd0, s}, 8'd0);
    step(1);  check("os_t4_s", {6'd0, s}, 8'd1);
    step(4);  check("os_t8_s", {6'd0, s}, 8'd2);
    step(4);  check("os_t12_s", {6'd0, s}, 8'd3);
    step(3);  check("os_t15", {valid, busy, s, data}, {1'b0, 1'b1, 2'd3, 4'h0});
    step(1);  check("os_t16", pk(), {1'b1, 1'b0, 2'd0, 4'b1010});
    step(1);  check("os_t17", pk(), {1'b0, 1'b0, 2'd0, 4'b1010});

    // Continuous, a=0110 then 1001; cont dropped during the second scan.
    a = 4'b0110; cont = 1'b1; start = 1'b1;
    step(1);                               // T0
    start = 1'b0;
    step(16); check("cont_t16", pk(), {1'b1, 1'b1, 2'd0, 4'b0110});
    step(1);                               // T0+17
    check("cont_t17", pk(), {1'b0, 1'b1, 2'd0, 4'b0110});
    a = 4'b1001; cont = 1'b0;
    step(14); check("cont_t31", pk(), {1'b0, 1'b1, 2'd3, 4'b0110});
    step(1);  check("cont_t32", pk(), {1'b1, 1'b0, 2'd0, 4'b1001});
    step(2);  check("cont_idle", pk(), {1'b0, 1'b0, 2'd0, 4'b1001});

    // start held high throughout: no restart mid-scan, re-accepted one
    // cycle after the valid.
    a = 4'b0011; start = 1'b1;
    step(1);                               // T0
    step(8);  check("hold_t8", pk(), {1'b0, 1'b1, 2'd2, 4'b1001});
    step(8);  check("hold_t16", pk(), {1'b1, 1'b0, 2'd0, 4'b0011});
    step(1);  check("hold_t17", pk(), {1'b0, 1'b1, 2'd0, 4'b0011});
    start = 1'b0;
    a = 4'b1100;
    step(16); check("hold_t33", pk(), {1'b1, 1'b0, 2'd0, 4'b1100});

    // Reset mid-scan at T0+7, a=1111: async clear, no valid, then clean rescan.
    step(2);
    a = 4'b1111; start = 1'b1;
    step(1);                               // T0
    start = 1'b0;
    step(7);
    #2 rst = 1'b1;
    #1 check("rst_async", pk(), 8'h00);
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (valid !== 1'b0 || data !== 4'h0) check("rst_quiet", pk(), 8'h00);
    end
    check("rst_after", pk(), 8'h00);
    start = 1'b1;
    step(1);                               // T0
    start = 1'b0;
    step(15); check("rst_t15", {7'd0, valid}, 8'd0);
    step(1);  check("rst_t16", pk(), {1'b1, 1'b0, 2'd0, 4'b1111});

    // DWELL=1, a1=0001: select steps every cycle, valid at T0+4.
    a1 = 4'b0001; start1 = 1'b1;
    step(1);                               // T0
    start1 = 1'b0;
    check("d1_t0", {valid1, busy1, s1, data1}, {1'b0, 1'b1, 2'd0, 4'h0});
    step(1);  check("d1_t1_s", {6'd0, s1}, 8'd1);
    step(1);  check("d1_t2_s", {6'd0, s1}, 8'd2);
    step(1);  check("d1_t3", {valid1, busy1, s1, data1}, {1'b0, 1'b1, 2'd3, 4'h0});
    step(1);  check("d1_t4", {valid1, busy1, s1, data1}, {1'b1, 1'b0, 2'd0, 4'b0001});
    step(1);  check("d1_t5", {valid1, busy1, s1, data1}, {1'b0, 1'b0, 2'd0, 4'b0001});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
